// File: rtl/switch_allocator_pkg.sv
// Port indices, one-hot constants and allocator types for the 12-port tile router.
// Shared by route computation and the switch allocator.
package switch_allocator_pkg;

    localparam int NUM_PORTS = 12;

    localparam int PORT_N     = 0;
    localparam int PORT_S     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_NE    = 4;
    localparam int PORT_NW    = 5;
    localparam int PORT_SE    = 6;
    localparam int PORT_SW    = 7;
    localparam int PORT_SER_N = 8;
    localparam int PORT_SER_S = 9;
    localparam int PORT_SER_E = 10;
    localparam int PORT_SER_W = 11;

    localparam logic [NUM_PORTS-1:0] OH_N     = NUM_PORTS'(1) << PORT_N;
    localparam logic [NUM_PORTS-1:0] OH_S     = NUM_PORTS'(1) << PORT_S;
    localparam logic [NUM_PORTS-1:0] OH_E     = NUM_PORTS'(1) << PORT_E;
    localparam logic [NUM_PORTS-1:0] OH_W     = NUM_PORTS'(1) << PORT_W;
    localparam logic [NUM_PORTS-1:0] OH_NE    = NUM_PORTS'(1) << PORT_NE;
    localparam logic [NUM_PORTS-1:0] OH_NW    = NUM_PORTS'(1) << PORT_NW;
    localparam logic [NUM_PORTS-1:0] OH_SE    = NUM_PORTS'(1) << PORT_SE;
    localparam logic [NUM_PORTS-1:0] OH_SW    = NUM_PORTS'(1) << PORT_SW;
    localparam logic [NUM_PORTS-1:0] OH_SER_N = NUM_PORTS'(1) << PORT_SER_N;
    localparam logic [NUM_PORTS-1:0] OH_SER_S = NUM_PORTS'(1) << PORT_SER_S;
    localparam logic [NUM_PORTS-1:0] OH_SER_E = NUM_PORTS'(1) << PORT_SER_E;
    localparam logic [NUM_PORTS-1:0] OH_SER_W = NUM_PORTS'(1) << PORT_SER_W;

    typedef enum logic {
        OUT_IDLE,
        OUT_LOCKED
    } out_state_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps modulo N.
// Returns a one-hot grant and whether any request was present.
module rr_arbiter
    import switch_allocator_pkg::*;
#(
    parameter  int N = NUM_PORTS,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         any
);

    int idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole output allocator: round-robin lock per output until the tail flit,
// with a watchdog that frees outputs held by a stalled owner.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int N_PORTS   = NUM_PORTS,
    parameter int TIMEOUT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           req_valid,
    input  logic [N_PORTS*N_PORTS-1:0]   req_port,
    input  logic [N_PORTS-1:0]           req_tail,
    input  logic [N_PORTS-1:0]           credit_avail,
    output logic [N_PORTS-1:0]           grant,
    output logic [N_PORTS*N_PORTS-1:0]   xbar_sel,
    output logic [N_PORTS-1:0]           out_busy,
    output logic [N_PORTS-1:0]           timeout,
    output logic                         err_onehot
);

    localparam int PW = $clog2(N_PORTS);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    out_state_e           state_q [N_PORTS];
    out_state_e           state_d [N_PORTS];
    logic [PW-1:0]        owner_q [N_PORTS];
    logic [PW-1:0]        owner_d [N_PORTS];
    logic [PW-1:0]        ptr_q   [N_PORTS];
    logic [PW-1:0]        ptr_d   [N_PORTS];
    logic [TIMEOUT_W-1:0] wd_q    [N_PORTS];
    logic [TIMEOUT_W-1:0] wd_d    [N_PORTS];
    logic [N_PORTS-1:0]   arb_req [N_PORTS];
    logic [N_PORTS-1:0]   arb_gnt [N_PORTS];
    logic [N_PORTS-1:0]   arb_any;
    logic [N_PORTS-1:0]   req_ok;
    logic [N_PORTS-1:0]   owns;
    logic [N_PORTS-1:0]   xfer;
    logic                 bad;
    logic                 err_q;

    // Malformed requests never reach arbitration; inputs already owning an output stay out too.
    always_comb begin
        req_ok = '0;
        bad    = 1'b0;
        owns   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req_valid[i]) begin
                if ($countones(req_port[i*N_PORTS +: N_PORTS]) == 1) req_ok[i] = 1'b1;
                else bad = 1'b1;
            end
        end
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == OUT_LOCKED) owns[owner_q[o]] = 1'b1;
        end
        for (int o = 0; o < N_PORTS; o++) begin
            arb_req[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                arb_req[o][i] = req_ok[i] & ~owns[i] & req_port[i*N_PORTS+o];
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        rr_arbiter #(.N(N_PORTS)) u_arb (
            .req (arb_req[o]),
            .ptr (ptr_q[o]),
            .gnt (arb_gnt[o]),
            .any (arb_any[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
                wd_q[o]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                wd_q[o]    <= wd_d[o];
            end
            err_q <= err_q | bad;
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            wd_d[o]    = wd_q[o];
            unique case (state_q[o])
                OUT_IDLE: begin
                    wd_d[o] = '0;
                    if (arb_any[o] && credit_avail[o]) begin
                        state_d[o] = OUT_LOCKED;
                        for (int i = 0; i < N_PORTS; i++) begin
                            if (arb_gnt[o][i]) owner_d[o] = PW'(i);
                        end
                    end
                end
                OUT_LOCKED: begin
                    // A tail that lands on the expiry cycle releases normally.
                    if (xfer[o] && req_tail[owner_q[o]]) begin
                        state_d[o] = OUT_IDLE;
                        wd_d[o]    = '0;
                    end else if (xfer[o]) begin
                        wd_d[o] = '0;
                    end else if (timeout[o]) begin
                        state_d[o] = OUT_IDLE;
                        wd_d[o]    = '0;
                    end else begin
                        wd_d[o] = wd_q[o] + TIMEOUT_W'(1);
                    end
                    if (state_d[o] == OUT_IDLE) begin
                        ptr_d[o] = (owner_q[o] == PW'(N_PORTS-1)) ? '0
                                 : owner_q[o] + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant    = '0;
        xbar_sel = '0;
        out_busy = '0;
        timeout  = '0;
        xfer     = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == OUT_LOCKED) begin
                out_busy[o] = 1'b1;
                xbar_sel[o*N_PORTS + int'(owner_q[o])] = 1'b1;
                if (req_valid[owner_q[o]] && credit_avail[o]) begin
                    grant[owner_q[o]] = 1'b1;
                    xfer[o]           = 1'b1;
                end
                timeout[o] = !xfer[o] && (wd_q[o] == WD_MAX);
            end
        end
    end

    assign err_onehot = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboarded random bench for switch_allocator against an owner/pointer
// reference model; a monitor compares the DUT on every falling edge.
module tb_switch_allocator;

    localparam int N      = 12;
    localparam int TW     = 3;
    localparam int WD_MAX = (1 << TW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*N-1:0]   req_port;
    logic [N-1:0]     req_tail;
    logic [N-1:0]     credit_avail;
    logic [N-1:0]     grant;
    logic [N*N-1:0]   xbar_sel;
    logic [N-1:0]     out_busy;
    logic [N-1:0]     timeout;
    logic             err_onehot;

    always #5 clk = ~clk;

    switch_allocator #(.N_PORTS(N), .TIMEOUT_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .req_tail     (req_tail),
        .credit_avail (credit_avail),
        .grant        (grant),
        .xbar_sel     (xbar_sel),
        .out_busy     (out_busy),
        .timeout      (timeout),
        .err_onehot   (err_onehot)
    );

    typedef struct {
        logic [N-1:0]   grant;
        logic [N*N-1:0] xsel;
        logic [N-1:0]   busy;
        logic [N-1:0]   tmo;
        logic           err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: owner input per output (-1 = free), pointer, stall count.
    int           own   [N];
    int           ptr   [N];
    int           stall [N];
    bit           err_m;
    logic [N-1:0] m_grant;

    function automatic logic [N-1:0] oh(input int o);
        logic [N-1:0] one;
        one = 1;
        return one << o;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            own[o]   = -1;
            ptr[o]   = 0;
            stall[o] = 0;
        end
        err_m = 0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*N-1:0] p,
                        input logic [N-1:0] t, input logic [N-1:0] c, input bit r);
        exp_t e;
        bit   owns [N];
        bit   xf   [N];
        bit   found;
        int   i;
        @(posedge clk);
        #1;
        req_valid    = v;
        req_port     = p;
        req_tail     = t;
        credit_avail = c;
        rst          = r;
        e.grant = '0; e.xsel = '0; e.busy = '0; e.tmo = '0; e.err = err_m;
        for (int k = 0; k < N; k++) begin owns[k] = 0; xf[k] = 0; end
        for (int o = 0; o < N; o++) begin
            if (own[o] >= 0) begin
                i = own[o];
                owns[i] = 1;
                e.busy[o] = 1'b1;
                e.xsel[o*N+i] = 1'b1;
                xf[o] = v[i] && c[o];
                if (xf[o]) e.grant[i] = 1'b1;
                e.tmo[o] = !xf[o] && (stall[o] == WD_MAX);
            end
        end
        sbq.push_back(e);
        m_grant = e.grant;
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < N; k++)
                if (v[k] && $countones(p[k*N +: N]) != 1) err_m = 1;
            for (int o = 0; o < N; o++) begin
                if (own[o] >= 0) begin
                    i = own[o];
                    if (xf[o]) begin
                        stall[o] = 0;
                        if (t[i]) begin own[o] = -1; ptr[o] = (i + 1) % N; end
                    end else if (e.tmo[o]) begin
                        own[o] = -1; ptr[o] = (i + 1) % N; stall[o] = 0;
                    end else begin
                        stall[o]++;
                    end
                end else if (c[o]) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        i = (ptr[o] + k) % N;
                        if (!found && v[i] && !owns[i] && p[i*N+o]
                            && $countones(p[i*N +: N]) == 1) begin
                            own[o] = i;
                            found  = 1;
                        end
                    end
                end
            end
        end
    endtask

    // Monitor: one scoreboard entry per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp += 5;
                if (grant !== e.grant) begin
                    n_bad++;
                    $display("FAIL grant t=%0t got %h want %h", $time, grant, e.grant);
                end
                if (xbar_sel !== e.xsel) begin
                    n_bad++;
                    $display("FAIL xbar_sel t=%0t got %h want %h", $time, xbar_sel, e.xsel);
                end
                if (out_busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL out_busy t=%0t got %h want %h", $time, out_busy, e.busy);
                end
                if (timeout !== e.tmo) begin
                    n_bad++;
                    $display("FAIL timeout t=%0t got %h want %h", $time, timeout, e.tmo);
                end
                if (err_onehot !== e.err) begin
                    n_bad++;
                    $display("FAIL err_onehot t=%0t got %b want %b", $time, err_onehot, e.err);
                end
            end
        end
    end

    initial begin
        logic [N-1:0]   v, t, c;
        logic [N*N-1:0] p;
        int tgt [N];
        int rem [N];
        int mute[N];

        rst = 1'b1; req_valid = '0; req_port = '0; req_tail = '0; credit_avail = '0;
        repeat (2) @(posedge clk);
        model_reset();
        m_grant = '0;

        // Single 3-flit packet in0 -> E.
        p = '0; p[0*N +: N] = oh(2); c = '1;
        for (int k = 0, f = 0; k < 6; k++) begin
            v = (f < 3) ? N'(1) : '0;
            t = (f == 2) ? N'(1) : '0;
            step(v, p, t, c, 0);
            if (m_grant[0]) f++;
        end

        // Contention on SER_N from in0, in3, in5 with single-flit packets.
        v = oh(0) | oh(3) | oh(5); p = '0;
        for (int i = 0; i < N; i++) p[i*N +: N] = oh(8);
        for (int k = 0; k < 9; k++) begin
            step(v, p, '1, '1, 0);
            v &= ~m_grant;
        end

        // Backpressure then watchdog: in1 owns N, in2 waits.
        p = '0; p[1*N +: N] = oh(0); p[2*N +: N] = oh(0);
        step(oh(1), p, '0, '1, 0);
        for (int k = 0; k < 4; k++) step(oh(1) | oh(2), p, '0, ~oh(0), 0);
        step(oh(1) | oh(2), p, '0, '1, 0);
        for (int k = 0; k < 12; k++) step(oh(2), p, '0, '1, 0);
        step('0, p, '0, '1, 1);

        // Malformed request, then reset mid-packet.
        p = '0; p[4*N +: N] = 12'h005; p[6*N +: N] = oh(3);
        step(oh(4), p, '0, '1, 0);
        for (int k = 0; k < 3; k++) step(oh(6), p, '0, '1, 0);
        step(oh(6), p, '0, '1, 1);
        step(oh(6), p, '0, '1, 0);

        // Randomized traffic with muted owners, bad ports and periodic resets.
        for (int i = 0; i < N; i++) begin rem[i] = 0; mute[i] = 0; tgt[i] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r;
            r = (cyc % 300) == 299;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    tgt[i] = $urandom_range(0, 1) ? $urandom_range(0, 2)
                                                  : $urandom_range(0, N - 1);
                    rem[i] = $urandom_range(1, 5);
                end else if ($urandom_range(0, 49) == 0) begin
                    tgt[i] = $urandom_range(0, N - 1);
                end
                if (mute[i] > 0) mute[i]--;
                else if ($urandom_range(0, 199) == 0) mute[i] = 12;
                v[i] = (mute[i] == 0) && ($urandom_range(0, 9) < 7);
                p[i*N +: N] = oh(tgt[i]);
                if ($urandom_range(0, 1999) == 0) p[i*N +: N] = 12'h005;
                t[i] = (rem[i] == 1);
                c[i] = ($urandom_range(0, 9) < 8);
            end
            step(v, p, t, c, r);
            for (int i = 0; i < N; i++) begin
                if (r) rem[i] = 0;
                else if (m_grant[i]) rem[i]--;
            end
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
